spi_codec_target: RTL and testbench
===================================

Name: spi_codec_target

Overview:
- SPI target (slave) end of the pedal's ADC/DAC serial link: the far side of the pedal's SPI master.
- Serves the master's frames from on-chip sample/trim sources. Used as the on-chip loopback/test codec and as the pad-side target when an external MCU drives the pedal bus.
- Oversamples sclk/cs/mosi in the system clock domain, decodes an 8-bit command, then runs a 16-bit full-duplex data phase.
- Returns the ADC sample or a trim value on miso, and captures the DAC word from mosi.

Parameters:
- ID_BYTE, 8'hA5, constant shifted out on miso during the command phase.
- SYNC_STAGES, 2, flop stages on sclk, cs and mosi before edge detection (minimum 2).

Ports:
- wb_clk_i  in  1  system clock; must be at least 8x the sclk frequency.
- wb_rst_i  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
- cs  in  1  chip select, active low.
- mosi  in  1  master-to-target data, MSB first.
- miso  out  1  target-to-master data, MSB first.
- miso_oeb  out  1  pad output-enable bar for miso; 1 = tristate.
- adc_sample  in  16  audio sample source.
- trim1, trim2, trim3, trim4  in  8 each  trim values.
- dac_sample  out  16  last committed DAC word.
- dac_valid  out  1  one-cycle pulse when dac_sample updates.
- cmd_o  out  8  last fully received command byte.
- frame_err  out  1  one-cycle pulse on a truncated frame.
- busy  out  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset values:
  - miso = 0, miso_oeb = 1, dac_sample = 0, dac_valid = 0, cmd_o = 0, frame_err = 0, busy = 0.
  - Sync flops reset to cs = 1, sclk = 0, mosi = 0. State = IDLE.
- Edge detection:
  - sclk and cs rise/fall are detected on the last sync stage versus its delayed copy.
  - Detection latency is SYNC_STAGES + 1 cycles of wb_clk_i.
- Frame format (24 sclk periods):
  - Bits 23..16: command. cmd[7] = DAC write; cmd[2:0] = channel (0 = adc, 1..4 = trim1..trim4, 5..7 = invalid).
  - Bits 15..0: data.
- Sampling: mosi is sampled on detected sclk rise; miso changes only on detected sclk fall or on cs fall.
- State IDLE:
  - miso_oeb = 1.
  - Detected cs fall: snapshot adc_sample and trim1..trim4 into a frame-coherent buffer, load shifter with ID_BYTE, drive miso = ID_BYTE[7], set miso_oeb = 0, bitcnt = 0, go to CMD.
- State CMD:
  - Each sclk rise shifts mosi into cmd_sr and increments bitcnt.
  - Each sclk fall drives the next ID_BYTE bit.
  - On the 8th rise: cmd_o <= cmd_sr, select response word, go to DATA.
  - Response word: ch0 = snapshot adc; ch1..4 = {8'h00, trimN}; ch5..7 = 16'h0000.
- State DATA:
  - The first sclk fall after entry drives response[15]; each following fall drives the next bit.
  - Each sclk rise shifts mosi into data_sr.
  - On the 16th rise (bitcnt = 24): if cmd_o[7], dac_sample <= data_sr and dac_valid pulses the next cycle. Go to DONE.
- State DONE:
  - miso held 0; additional sclk edges are ignored (no wrap, no second frame).
  - Detected cs rise: go to IDLE, miso_oeb = 1.
- Truncated frame:
  - cs rise in CMD or DATA: frame_err pulses one cycle, dac_sample is unchanged, go to IDLE.
  - cmd_o updates only if the CMD phase completed.
- Simultaneous cs rise and sclk edge in the same cycle: cs takes priority, the edge is discarded, and the truncation rule applies.
- cs already low when reset releases: stay in IDLE until a new cs fall is seen; the partial frame is ignored.
- Reset asserted mid-frame: immediate return to reset values; no dac_valid and no frame_err.
- The snapshot buffer guarantees the returned word equals adc_sample at cs fall, even if adc_sample changes during the frame.

Decomposition:
- Shared package pedal_spi_pkg:
  - Constants SPI_CMD_BITS = 8, SPI_DATA_BITS = 16, SPI_FRAME_BITS = 24.
  - Channel codes CH_ADC = 0, CH_TRIM1..CH_TRIM4 = 1..4; CMD_DAC_WR_BIT = 7.
  - State enum IDLE, CMD, DATA, DONE.
- One sub-module, spi_in_sync: SYNC_STAGES synchronizer plus rise/fall detector. Instantiated for sclk and cs; mosi uses the sync path only.

Test Plan:
- Reset then frame: cmd 8'h00, data 16'h0000, adc_sample = 16'h1234 -> miso reads A5 then 16'h1234; no dac_valid; cmd_o = 8'h00.
- Frame cmd 8'h83, mosi data 16'hBEEF, trim3 = 8'h5A -> miso data = 16'h005A; dac_sample = 16'hBEEF with one dac_valid pulse.
- cmd 8'h80, adc_sample changed from 16'h1111 to 16'h2222 mid-frame -> miso returns 16'h1111 (snapshot at cs fall).
- cs rises after 12 sclk periods with cmd 8'h80 -> frame_err pulses once; dac_sample unchanged; cmd_o = 8'h80; next full frame works normally.
- Invalid channel cmd 8'h07 and 30 sclk periods in one frame -> data 16'h0000; miso = 0 for periods 25-30; busy drops only after cs rise.
- wb_rst_i asserted at bit 20 of a DAC write, released while cs still low -> no dac_valid; frame ignored until cs goes high and falls again; miso_oeb = 1 throughout.

Source files
------------

// File: rtl/pedal_spi_pkg.sv
// Shared definitions for the pedal SPI link: frame geometry, channel codes
// and the target-side frame state encoding.
package pedal_spi_pkg;

  localparam int unsigned SPI_CMD_BITS   = 8;
  localparam int unsigned SPI_DATA_BITS  = 16;
  localparam int unsigned SPI_FRAME_BITS = 24;

  localparam logic [2:0] CH_ADC   = 3'd0;
  localparam logic [2:0] CH_TRIM1 = 3'd1;
  localparam logic [2:0] CH_TRIM2 = 3'd2;
  localparam logic [2:0] CH_TRIM3 = 3'd3;
  localparam logic [2:0] CH_TRIM4 = 3'd4;

  localparam int unsigned CMD_DAC_WR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_codec_target_if.sv
// SPI pad bundle between the pedal SPI master and the codec target.
//   sclk, cs, mosi : master -> target (mode 0, cs active low, MSB first)
//   miso, miso_oeb : target -> master (miso_oeb = 1 tristates the pad)
interface spi_codec_target_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oeb;

  modport master (output sclk, output cs, output mosi, input miso, input miso_oeb);
  modport slave  (input sclk, input cs, input mosi, output miso, output miso_oeb);
endinterface

// File: rtl/spi_in_sync.sv
// Synchronizer plus edge detector for one asynchronous SPI input.
//   clk_i, rst_i : system clock, async active-high reset
//   d_i          : asynchronous input
//   rise_o/fall_o: one-cycle edge pulses, SYNC_STAGES+1 cycles after d_i moves
// Edges are suppressed until the chain holds only post-reset samples, so a
// level that differs from RST_VAL at reset release is not reported as an edge.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   lvl;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      dly_q   <= RST_VAL;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q   <= sync_q[SYNC_STAGES-1];
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign lvl    = sync_q[SYNC_STAGES-1];
  assign rise_o = prime_q[SYNC_STAGES] &  lvl & ~dly_q;
  assign fall_o = prime_q[SYNC_STAGES] & ~lvl &  dly_q;

endmodule

// File: rtl/spi_codec_target.sv
// SPI target end of the pedal ADC/DAC link (loopback/test codec).
//   wb_clk_i, wb_rst_i : system clock (>= 8x sclk), async active-high reset
//   spi (slave)        : sclk/cs/mosi in, miso/miso_oeb out
//   adc_sample, trim1..trim4 : response sources, snapshotted at cs fall
//   dac_sample/dac_valid     : committed DAC word and its update pulse
//   cmd_o      : last fully received command byte
//   frame_err  : one-cycle pulse when cs rises before the frame completes
//   busy       : high while a frame is in progress
// Frame: 8-bit command (ID_BYTE returned) then 16-bit full-duplex data.
module spi_codec_target
  import pedal_spi_pkg::*;
#(
  parameter logic [7:0]  ID_BYTE     = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  spi_codec_target_if.slave   spi,
  input  logic [15:0]         adc_sample,
  input  logic [7:0]          trim1,
  input  logic [7:0]          trim2,
  input  logic [7:0]          trim3,
  input  logic [7:0]          trim4,
  output logic [15:0]         dac_sample,
  output logic                dac_valid,
  output logic [7:0]          cmd_o,
  output logic                frame_err,
  output logic                busy
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(spi.sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(spi.cs), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // mosi shares the sclk chain depth so it is sampled at the same age as the edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) mosi_sync_q <= '0;
    else          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e       state_q, state_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  // The final command/data bit is taken straight from mosi, so the shifters
  // hold one bit less than the field they assemble.
  logic [SPI_CMD_BITS-2:0]  cmd_sr_q, cmd_sr_d;
  logic [SPI_DATA_BITS-2:0] data_sr_q, data_sr_d;
  // tx_sr holds the bits not yet driven; each sclk fall moves its MSB to miso.
  logic [15:0]      tx_sr_q, tx_sr_d;
  logic             miso_q, miso_d, oeb_q, oeb_d;
  logic [15:0]      snap_adc_q, snap_adc_d;
  logic [3:0][7:0]  snap_trim_q, snap_trim_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [15:0]      dac_q, dac_d;
  logic             dac_vld_q, dac_vld_d, ferr_q, ferr_d;

  logic [7:0]       new_cmd;
  logic [15:0]      new_data, resp;

  assign new_cmd  = {cmd_sr_q, mosi_s};
  assign new_data = {data_sr_q, mosi_s};

  always_comb begin
    resp = '0;
    case (new_cmd[2:0])
      CH_ADC:   resp = snap_adc_q;
      CH_TRIM1: resp = {8'h00, snap_trim_q[0]};
      CH_TRIM2: resp = {8'h00, snap_trim_q[1]};
      CH_TRIM3: resp = {8'h00, snap_trim_q[2]};
      CH_TRIM4: resp = {8'h00, snap_trim_q[3]};
      default:  resp = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    cmd_sr_d    = cmd_sr_q;
    data_sr_d   = data_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    oeb_d       = oeb_q;
    snap_adc_d  = snap_adc_q;
    snap_trim_d = snap_trim_q;
    cmd_d       = cmd_q;
    dac_d       = dac_q;
    dac_vld_d   = 1'b0;
    ferr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        oeb_d = 1'b1;
        if (cs_fall) begin
          snap_adc_d  = adc_sample;
          snap_trim_d = {trim4, trim3, trim2, trim1};
          tx_sr_d     = {ID_BYTE[6:0], 9'b0};
          miso_d      = ID_BYTE[7];
          oeb_d       = 1'b0;
          bitcnt_d    = '0;
          state_d     = CMD;
        end
      end

      CMD, DATA: begin
        // cs rise wins over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          ferr_d  = 1'b1;
          miso_d  = 1'b0;
          oeb_d   = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall) begin
          miso_d  = tx_sr_q[15];
          tx_sr_d = {tx_sr_q[14:0], 1'b0};
        end else if (sclk_rise) begin
          bitcnt_d = bitcnt_q + 5'd1;
          if (state_q == CMD) begin
            cmd_sr_d = new_cmd[6:0];
            if (bitcnt_q == 5'(SPI_CMD_BITS - 1)) begin
              cmd_d   = new_cmd;
              tx_sr_d = resp;
              state_d = DATA;
            end
          end else begin
            data_sr_d = new_data[14:0];
            if (bitcnt_q == 5'(SPI_FRAME_BITS - 1)) begin
              if (cmd_q[CMD_DAC_WR_BIT]) begin
                dac_d     = new_data;
                dac_vld_d = 1'b1;
              end
              miso_d  = 1'b0;
              state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          oeb_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      cmd_sr_q    <= '0;
      data_sr_q   <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      oeb_q       <= 1'b1;
      snap_adc_q  <= '0;
      snap_trim_q <= '0;
      cmd_q       <= '0;
      dac_q       <= '0;
      dac_vld_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      cmd_sr_q    <= cmd_sr_d;
      data_sr_q   <= data_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      oeb_q       <= oeb_d;
      snap_adc_q  <= snap_adc_d;
      snap_trim_q <= snap_trim_d;
      cmd_q       <= cmd_d;
      dac_q       <= dac_d;
      dac_vld_q   <= dac_vld_d;
      ferr_q      <= ferr_d;
    end
  end

  assign spi.miso     = miso_q;
  assign spi.miso_oeb = oeb_q;
  assign dac_sample   = dac_q;
  assign dac_valid    = dac_vld_q;
  assign cmd_o        = cmd_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_codec_target.sv
// Bench for spi_codec_target: a mode-0 SPI master task drives directed and
// random frames; a frame-level reference model predicts miso bits, DAC
// commits, cmd_o and error pulses.
module tb_spi_codec_target;

  localparam int H = 8;  // sclk half period in wb_clk_i cycles

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] adc_sample = '0;
  logic [7:0]  trim [4];
  logic [15:0] dac_sample;
  logic        dac_valid;
  logic [7:0]  cmd_o;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_dv = 0, n_fe = 0, n_oeb_low = 0;
  bit oeb_watch = 1'b0;

  logic [15:0] exp_dac;
  logic [7:0]  exp_cmd;
  int          fno = 0;

  spi_codec_target_if spi_bus ();

  spi_codec_target #(.ID_BYTE(8'hA5), .SYNC_STAGES(2)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .spi        (spi_bus),
    .adc_sample (adc_sample),
    .trim1      (trim[0]),
    .trim2      (trim[1]),
    .trim3      (trim[2]),
    .trim4      (trim[3]),
    .dac_sample (dac_sample),
    .dac_valid  (dac_valid),
    .cmd_o      (cmd_o),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) begin
    if (dac_valid) n_dv++;
    if (frame_err) n_fe++;
    if (oeb_watch && !spi_bus.miso_oeb) n_oeb_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s (frame %0d): observed 'h%0h expected 'h%0h", tag, fno, obs, expv);
    end
  endtask

  function automatic logic [15:0] ref_resp(input logic [2:0] ch, input logic [15:0] adc);
    if (ch == 3'd0) return adc;
    if (ch <= 3'd4) return {8'h00, trim[ch - 3'd1]};
    return 16'h0000;
  endfunction

  // One master frame: nper sclk periods, optional reset pulse after rise rst_at,
  // adc_sample replaced by adc_after once the first rise has gone out.
  task automatic frame(input logic [7:0] cmd, input logic [15:0] data, input int nper,
                       input int rst_at, input logic [15:0] adc_after);
    logic [23:0] tx, expf;
    logic [7:0]  id;
    logic [31:0] rx, exp_rx;
    int dv0, fe0, oeb0, b, exp_dv, exp_fe;
    bit rst_hit;
    id = 8'hA5;
    tx = {cmd, data};
    expf = {id, ref_resp(cmd[2:0], adc_sample)};
    rx = '0; exp_rx = '0;
    dv0 = n_dv; fe0 = n_fe; oeb0 = n_oeb_low;
    rst_hit = (rst_at >= 0);
    fno++;

    @(negedge wb_clk_i);
    spi_bus.cs = 1'b0;
    spi_bus.mosi = tx[23];
    repeat (H) @(negedge wb_clk_i);
    for (int i = 0; i < nper; i++) begin
      rx = {rx[30:0], spi_bus.miso};
      exp_rx = {exp_rx[30:0], (i < 24) ? expf[23 - i] : 1'b0};
      spi_bus.sclk = 1'b1;
      if (i == 0) adc_sample = adc_after;
      repeat (H) @(negedge wb_clk_i);
      if (i == rst_at) begin
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        oeb_watch = 1'b1;
      end
      spi_bus.sclk = 1'b0;
      b = i + 1;
      spi_bus.mosi = (b < 24) ? tx[23 - b] : 1'b0;
      repeat (H) @(negedge wb_clk_i);
    end

    check("busy_in_frame", {31'b0, busy}, {31'b0, !rst_hit});
    check("oeb_in_frame", {31'b0, spi_bus.miso_oeb}, {31'b0, rst_hit});
    spi_bus.cs = 1'b1;
    repeat (4 * H) @(negedge wb_clk_i);
    oeb_watch = 1'b0;

    if (rst_hit) begin
      exp_dac = '0; exp_cmd = '0; exp_dv = 0; exp_fe = 0;
      check("oeb_after_reset", n_oeb_low - oeb0, 0);
    end else begin
      if (nper >= 8) exp_cmd = cmd;
      exp_dv = (nper >= 24 && cmd[7]) ? 1 : 0;
      if (exp_dv == 1) exp_dac = data;
      exp_fe = (nper < 24) ? 1 : 0;
      check("miso_bits", rx, exp_rx);
    end
    check("dac_valid_cnt", n_dv - dv0, exp_dv);
    check("frame_err_cnt", n_fe - fe0, exp_fe);
    check("dac_sample", {16'b0, dac_sample}, {16'b0, exp_dac});
    check("cmd_o", {24'b0, cmd_o}, {24'b0, exp_cmd});
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("oeb_idle", {31'b0, spi_bus.miso_oeb}, 32'd1);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [15:0] rd, ra;
    int          np, sel;

    trim[0] = 8'h11; trim[1] = 8'h22; trim[2] = 8'h33; trim[3] = 8'h44;
    spi_bus.cs = 1'b1; spi_bus.sclk = 1'b0; spi_bus.mosi = 1'b0;
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("rst_miso", {31'b0, spi_bus.miso}, 32'd0);
    check("rst_oeb", {31'b0, spi_bus.miso_oeb}, 32'd1);
    check("rst_dac", {16'b0, dac_sample}, 32'd0);
    check("rst_dac_valid", {31'b0, dac_valid}, 32'd0);
    check("rst_cmd", {24'b0, cmd_o}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    wb_rst_i = 1'b0;
    exp_dac = '0; exp_cmd = '0;
    repeat (5) @(negedge wb_clk_i);

    // Plain ADC read, no DAC write.
    adc_sample = 16'h1234;
    frame(8'h00, 16'h0000, 24, -1, 16'h1234);
    // trim3 read with DAC write.
    trim[2] = 8'h5A;
    frame(8'h83, 16'hBEEF, 24, -1, 16'h1234);
    // adc_sample changes mid-frame; snapshot must be returned.
    adc_sample = 16'h1111;
    frame(8'h80, 16'h0F0F, 24, -1, 16'h2222);
    // Truncated after 12 periods, then a normal frame.
    frame(8'h80, 16'hC3C3, 12, -1, 16'h2222);
    frame(8'h81, 16'h1357, 24, -1, 16'h2222);
    // Invalid channel with 30 periods.
    frame(8'h07, 16'hFFFF, 30, -1, 16'h2222);
    // Reset at bit 20 of a DAC write, released with cs low; then a normal frame.
    frame(8'h80, 16'h4444, 24, 20, 16'h2222);
    frame(8'h84, 16'hA0A0, 24, -1, 16'h3333);

    // Random frames against the model.
    for (int k = 0; k < 14; k++) begin
      rc = 8'($urandom);
      rd = 16'($urandom);
      ra = 16'($urandom);
      adc_sample = 16'($urandom);
      for (int t = 0; t < 4; t++) trim[t] = 8'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0)      np = $urandom_range(1, 23);
      else if (sel == 3) np = $urandom_range(25, 30);
      else               np = 24;
      frame(rc, rd, np, -1, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
